// File: rtl/ascii_seq_pkg.sv
// Shared types and constants for the ASCII sequence sender.
// ASCII_CRLF_EN adds the CR and LF states and the byte selector.
package ascii_seq_pkg;

`ifdef ASCII_CRLF_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE,
    S_GAP,
    S_CR,
    S_LF
  } state_t;

  typedef enum logic [1:0] {
    SEL_CHAR,
    SEL_CR,
    SEL_LF
  } byte_sel_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE,
    S_GAP
  } state_t;
`endif

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic MODE_STEP  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  function automatic logic [7:0] next_char(
    input logic [7:0] p,
    input logic [7:0] first,
    input logic [7:0] last
  );
    return (p == last) ? first : p + 8'd1;
  endfunction

endpackage

// File: rtl/ascii_seq_sender_if.sv
// Trigger side and UART side signals of the sequence sender.
// master is the sender, slave is the button/UART environment.
interface ascii_seq_sender_if;
  logic       btn;
  logic       mode;
  logic       abort;
  logic       tx_done;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;

  modport master (
    input  btn,
    input  mode,
    input  abort,
    input  tx_done,
    output start,
    output tx_data,
    output busy
  );

  modport slave (
    output btn,
    output mode,
    output abort,
    output tx_done,
    input  start,
    input  tx_data,
    input  busy
  );
endinterface

// File: rtl/ascii_gap_timer.sv
// Loadable down-counter timing the pause between bytes.
// expired is high while enabled and the count has reached zero.
module ascii_gap_timer #(
  parameter int               GAP_W    = 16,
  parameter logic [GAP_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [GAP_W-1:0] cnt_q;

  // load wins over counting; count stops at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/ascii_seq_sender.sv
// STEP/BURST ASCII range generator feeding a UART start/tx_done handshake.
// Define ASCII_CRLF_EN to append CR LF after every completed sequence.
module ascii_seq_sender
  import ascii_seq_pkg::*;
#(
  parameter logic [7:0] CHAR_FIRST = 8'h30,
  parameter logic [7:0] CHAR_LAST  = 8'h7A,
  parameter int         GAP_CYCLES = 0,
  parameter int         GAP_W      = 16
) (
  input logic               clk,
  input logic               reset,
  ascii_seq_sender_if.master bus
);

  if (CHAR_LAST < CHAR_FIRST) begin : g_bad_range
    $error("ascii_seq_sender: CHAR_LAST below CHAR_FIRST");
  end

  if (GAP_W < 31 && GAP_CYCLES >= (1 << GAP_W)) begin : g_bad_gap
    $error("ascii_seq_sender: GAP_CYCLES does not fit GAP_W");
  end

  // LOAD itself is one idle cycle, so GAP holds GAP_CYCLES-1 cycles
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 2) : '0;

  state_t     state_q, state_n;
  logic       mode_q, mode_n;
  logic [7:0] ptr_q, ptr_n;
  logic [7:0] data_q, data_n;
  logic       start_q, start_n;
  logic       busy_q, busy_n;
  logic       gap_load;
  logic       gap_en;
  logic       gap_expired;
  logic       seq_end;

`ifdef ASCII_CRLF_EN
  byte_sel_t  sel_q, sel_n;
`endif

  ascii_gap_timer #(
    .GAP_W    (GAP_W),
    .LOAD_VAL (GAP_LOAD)
  ) u_gap (
    .clk     (clk),
    .reset   (reset),
    .load    (gap_load),
    .en      (gap_en),
    .expired (gap_expired)
  );

  assign gap_load = (state_q == S_WAIT_DONE) && bus.tx_done;
  assign gap_en   = (state_q == S_GAP);

  assign seq_end = (mode_q == MODE_STEP) ||
                   (ptr_q == CHAR_LAST) ||
                   bus.abort;

  // next-state and next-output decode
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    ptr_n   = ptr_q;
    data_n  = data_q;
    start_n = 1'b0;
`ifdef ASCII_CRLF_EN
    sel_n   = sel_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.btn) begin
          mode_n  = bus.mode;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        data_n  = ptr_q;
        start_n = 1'b1;
        state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.tx_done) begin
`ifdef ASCII_CRLF_EN
          unique case (sel_q)
            SEL_CHAR: begin
              ptr_n   = next_char(ptr_q, CHAR_FIRST, CHAR_LAST);
              sel_n   = seq_end ? SEL_CR : SEL_CHAR;
              state_n = S_GAP;
            end
            SEL_CR: begin
              sel_n   = SEL_LF;
              state_n = S_GAP;
            end
            default: begin
              sel_n   = SEL_CHAR;
              state_n = S_IDLE;
            end
          endcase
`else
          ptr_n   = next_char(ptr_q, CHAR_FIRST, CHAR_LAST);
          state_n = seq_end ? S_IDLE : S_GAP;
`endif
        end
      end
      S_GAP: begin
        if (gap_expired) begin
`ifdef ASCII_CRLF_EN
          unique case (sel_q)
            SEL_CR:  state_n = S_CR;
            SEL_LF:  state_n = S_LF;
            default: state_n = S_LOAD;
          endcase
`else
          state_n = S_LOAD;
`endif
        end
      end
`ifdef ASCII_CRLF_EN
      S_CR: begin
        data_n  = ASCII_CR;
        start_n = 1'b1;
        state_n = S_WAIT_DONE;
      end
      S_LF: begin
        data_n  = ASCII_LF;
        start_n = 1'b1;
        state_n = S_WAIT_DONE;
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_STEP;
      ptr_q   <= CHAR_FIRST;
      data_q  <= CHAR_FIRST;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ASCII_CRLF_EN
      sel_q   <= SEL_CHAR;
`endif
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      ptr_q   <= ptr_n;
      data_q  <= data_n;
      start_q <= start_n;
      busy_q  <= busy_n;
`ifdef ASCII_CRLF_EN
      sel_q   <= sel_n;
`endif
    end
  end

  assign bus.start   = start_q;
  assign bus.tx_data = data_q;
  assign bus.busy    = busy_q;

endmodule
